// File: rtl/stream_join_fifo_if.sv
// Handshake bundle for stream_join_fifo: per-channel input stb/ack streams,
// the joined output stream and per-channel occupancy.
interface stream_join_fifo_if #(
    parameter int WIDTH     = 32,
    parameter int NUM_CH    = 3,
    parameter int ADDR_BITS = 4
);
    logic [NUM_CH*WIDTH-1:0]         in_data;
    logic [NUM_CH-1:0]               in_stb;
    logic [NUM_CH-1:0]               in_ack;
    logic [NUM_CH*WIDTH-1:0]         out_data;
    logic                            out_stb;
    logic                            out_ack;
    logic [NUM_CH*(ADDR_BITS+1)-1:0] level;

    modport master (
        output in_data, in_stb, out_ack,
        input  in_ack, out_data, out_stb, level
    );

    modport slave (
        input  in_data, in_stb, out_ack,
        output in_ack, out_data, out_stb, level
    );
endinterface

// File: rtl/stream_join_fifo.sv
// NUM_CH independent stb/ack queues joined into one registered output beat.
// Optional almost_full output: define STREAM_JOIN_FIFO_ALMOST_FULL_EN.
module stream_join_fifo #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 16,
    parameter int NUM_CH    = 3,
    parameter int ADDR_BITS = 4
`ifdef STREAM_JOIN_FIFO_ALMOST_FULL_EN
    ,
    parameter int AF_THRESH = DEPTH - 2
`endif
) (
    input  logic               aclk,
    input  logic               rstn,
`ifdef STREAM_JOIN_FIFO_ALMOST_FULL_EN
    output logic [NUM_CH-1:0]  almost_full,
`endif
    stream_join_fifo_if.slave  bus
);
    localparam int                   CW       = ADDR_BITS + 1;
    localparam logic [CW-1:0]        CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
    localparam logic [ADDR_BITS-1:0] PTR_LAST = ADDR_BITS'(DEPTH - 1);
    localparam logic [ADDR_BITS-1:0] PTR_ONE  = ADDR_BITS'(1);

    logic [WIDTH-1:0]        mem_q   [NUM_CH][DEPTH];
    logic [ADDR_BITS-1:0]    wptr_q  [NUM_CH];
    logic [ADDR_BITS-1:0]    wptr_d  [NUM_CH];
    logic [ADDR_BITS-1:0]    rptr_q  [NUM_CH];
    logic [ADDR_BITS-1:0]    rptr_d  [NUM_CH];
    logic [CW-1:0]           count_q [NUM_CH];
    logic [CW-1:0]           count_d [NUM_CH];
    logic                    out_stb_q, out_stb_d;
    logic [NUM_CH*WIDTH-1:0] out_data_q, out_data_d;
    logic [NUM_CH-1:0]       in_ack;
    logic [NUM_CH-1:0]       push;
    logic                    all_ready;
    logic                    load;

    // in_ack depends only on registered counts, so no input-to-ack path exists
    always_comb begin
        in_ack    = '0;
        push      = '0;
        all_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            in_ack[i] = (count_q[i] != CNT_FULL);
            push[i]   = bus.in_stb[i] & in_ack[i];
            if (count_q[i] == '0) begin
                all_ready = 1'b0;
            end
        end
        load = all_ready & (~out_stb_q | bus.out_ack);
    end

    always_comb begin
        out_stb_d  = out_stb_q;
        out_data_d = out_data_q;
        if (load) begin
            out_stb_d = 1'b1;
        end else if (out_stb_q && bus.out_ack) begin
            out_stb_d = 1'b0;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            wptr_d[i]  = wptr_q[i];
            rptr_d[i]  = rptr_q[i];
            count_d[i] = count_q[i];
            if (push[i]) begin
                wptr_d[i] = (wptr_q[i] == PTR_LAST) ? '0 : wptr_q[i] + PTR_ONE;
            end
            if (load) begin
                rptr_d[i] = (rptr_q[i] == PTR_LAST) ? '0 : rptr_q[i] + PTR_ONE;
                out_data_d[i*WIDTH +: WIDTH] = mem_q[i][rptr_q[i]];
            end
            case ({push[i], load})
                2'b10:   count_d[i] = count_q[i] + CNT_ONE;
                2'b01:   count_d[i] = count_q[i] - CNT_ONE;
                default: count_d[i] = count_q[i];
            endcase
        end
    end

    always_ff @(posedge aclk or negedge rstn) begin
        if (!rstn) begin
            out_stb_q  <= 1'b0;
            out_data_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                wptr_q[i]  <= '0;
                rptr_q[i]  <= '0;
                count_q[i] <= '0;
            end
        end else begin
            out_stb_q  <= out_stb_d;
            out_data_q <= out_data_d;
            for (int i = 0; i < NUM_CH; i++) begin
                wptr_q[i]  <= wptr_d[i];
                rptr_q[i]  <= rptr_d[i];
                count_q[i] <= count_d[i];
            end
        end
    end

    // Storage carries no reset; stale entries are unreachable once pointers clear
    always_ff @(posedge aclk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (push[i]) begin
                mem_q[i][wptr_q[i]] <= bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        bus.in_ack   = in_ack;
        bus.out_stb  = out_stb_q;
        bus.out_data = out_data_q;
        bus.level    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            bus.level[i*CW +: CW] = count_q[i];
        end
    end

`ifdef STREAM_JOIN_FIFO_ALMOST_FULL_EN
    localparam logic [CW-1:0] AF_LEVEL = CW'(AF_THRESH);

    logic [NUM_CH-1:0] af_q, af_d;

    // Computed from next-state counts so it stays aligned with level
    always_comb begin
        af_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            af_d[i] = (count_d[i] >= AF_LEVEL);
        end
    end

    always_ff @(posedge aclk or negedge rstn) begin
        if (!rstn) begin
            af_q <= '0;
        end else begin
            af_q <= af_d;
        end
    end

    assign almost_full = af_q;
`endif
endmodule

// File: tb/tb_stream_join_fifo.sv
// Directed and randomized bench for stream_join_fifo (DEPTH=16 and DEPTH=5 instances)
// checked against per-channel word queues.
module tb_stream_join_fifo;
    logic aclk = 1'b0;
    logic rstn = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   beats5 = 0;

    logic [31:0] q16 [3][$];
    logic [31:0] q5  [3][$];

    stream_join_fifo_if #(.WIDTH(32), .NUM_CH(3), .ADDR_BITS(4)) b16 ();
    stream_join_fifo_if #(.WIDTH(32), .NUM_CH(3), .ADDR_BITS(3)) b5 ();

    stream_join_fifo #(.WIDTH(32), .DEPTH(16), .NUM_CH(3), .ADDR_BITS(4)) dut16 (
        .aclk(aclk), .rstn(rstn), .bus(b16.slave));
    stream_join_fifo #(.WIDTH(32), .DEPTH(5), .NUM_CH(3), .ADDR_BITS(3)) dut5 (
        .aclk(aclk), .rstn(rstn), .bus(b5.slave));

    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time budget expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [95:0] rnd96();
        return {$urandom, $urandom, $urandom};
    endfunction

    // One clock cycle on the DEPTH=16 instance with model bookkeeping.
    task automatic cyc16(input logic [2:0] stb, input logic [95:0] data, input logic ack);
        logic [95:0] exp;
        logic        miss;
        b16.in_stb  = stb;
        b16.in_data = data;
        b16.out_ack = ack;
        if (b16.out_stb === 1'b1 && ack) begin
            exp  = '0;
            miss = 1'b0;
            for (int c = 0; c < 3; c++) begin
                if (q16[c].size() == 0) miss = 1'b1;
                else exp[c*32 +: 32] = q16[c].pop_front();
            end
            chk("beat16_src", {127'b0, miss}, 128'b0);
            chk("beat16", {32'b0, b16.out_data}, {32'b0, exp});
        end
        for (int c = 0; c < 3; c++) begin
            if (stb[c] && b16.in_ack[c]) q16[c].push_back(data[c*32 +: 32]);
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic cyc5(input logic [2:0] stb, input logic [95:0] data, input logic ack,
                        output logic [2:0] acc);
        logic [95:0] exp;
        logic        miss;
        logic [31:0] n;
        b5.in_stb  = stb;
        b5.in_data = data;
        b5.out_ack = ack;
        acc = '0;
        if (b5.out_stb === 1'b1 && ack) begin
            exp  = '0;
            miss = 1'b0;
            for (int c = 0; c < 3; c++) begin
                if (q5[c].size() == 0) miss = 1'b1;
                else exp[c*32 +: 32] = q5[c].pop_front();
            end
            n = 32'(beats5);
            chk("beat5_src", {127'b0, miss}, 128'b0);
            chk("beat5", {32'b0, b5.out_data}, {32'b0, exp});
            chk("wrap_seq", {32'b0, b5.out_data}, {32'b0, n, n, n});
            beats5++;
        end
        for (int c = 0; c < 3; c++) begin
            if (stb[c] && b5.in_ack[c]) begin
                q5[c].push_back(data[c*32 +: 32]);
                acc[c] = 1'b1;
            end
        end
        @(posedge aclk);
        #1;
    endtask

    initial begin
        logic [95:0] d;
        logic [95:0] b1;
        logic [31:0] w0_first;
        logic [2:0]  stb;
        logic [2:0]  acc;
        logic        over;
        int          next5 [3];
        int          maxsz;
        int          left;

        b16.in_stb = '0; b16.in_data = '0; b16.out_ack = 1'b0;
        b5.in_stb  = '0; b5.in_data  = '0; b5.out_ack  = 1'b0;

        // Reset asserted before any clock edge
        #1 rstn = 1'b0;
        #1;
        chk("rst_out_stb", {127'b0, b16.out_stb}, 128'b0);
        chk("rst_in_ack", {125'b0, b16.in_ack}, {125'b0, 3'b111});
        chk("rst_level", {113'b0, b16.level}, 128'b0);
        chk("rst_out_data", {32'b0, b16.out_data}, 128'b0);
        @(posedge aclk); @(posedge aclk); #1;
        rstn = 1'b1;
        @(posedge aclk); @(posedge aclk); #1;
        chk("rel_out_stb", {127'b0, b16.out_stb}, 128'b0);
        chk("rel_in_ack", {125'b0, b16.in_ack}, {125'b0, 3'b111});
        chk("rel_level", {113'b0, b16.level}, 128'b0);

        // Single joined beat
        d = {32'h40400000, 32'h40000000, 32'h3F800000};
        cyc16(3'b111, d, 1'b1);
        chk("single_stb_k", {127'b0, b16.out_stb}, 128'b0);
        chk("single_level_k", {113'b0, b16.level}, {113'b0, 5'd1, 5'd1, 5'd1});
        cyc16(3'b000, '0, 1'b1);
        chk("single_stb_k1", {127'b0, b16.out_stb}, {127'b0, 1'b1});
        chk("single_data", {32'b0, b16.out_data}, {32'b0, d});
        chk("single_level_k1", {113'b0, b16.level}, 128'b0);
        cyc16(3'b000, '0, 1'b1);
        chk("single_stb_done", {127'b0, b16.out_stb}, 128'b0);

        // Unbalanced: ch0 fills to DEPTH alone
        w0_first = '0;
        for (int k = 0; k < 16; k++) begin
            d = rnd96();
            if (k == 0) w0_first = d[31:0];
            cyc16(3'b001, d, 1'b1);
        end
        chk("unbal_in_ack", {125'b0, b16.in_ack}, {125'b0, 3'b110});
        chk("unbal_level", {113'b0, b16.level}, {113'b0, 5'd0, 5'd0, 5'd16});
        chk("unbal_stb", {127'b0, b16.out_stb}, 128'b0);
        cyc16(3'b001, rnd96(), 1'b1);
        chk("unbal_full_hold", {113'b0, b16.level}, {113'b0, 5'd0, 5'd0, 5'd16});
        cyc16(3'b110, rnd96(), 1'b1);
        chk("unbal_level2", {113'b0, b16.level}, {113'b0, 5'd1, 5'd1, 5'd16});
        cyc16(3'b000, '0, 1'b1);
        chk("unbal_beat_stb", {127'b0, b16.out_stb}, {127'b0, 1'b1});
        chk("unbal_beat_ch0", {96'b0, b16.out_data[31:0]}, {96'b0, w0_first});
        chk("unbal_level3", {113'b0, b16.level}, {113'b0, 5'd0, 5'd0, 5'd15});
        cyc16(3'b000, '0, 1'b1);
        chk("unbal_one_beat", {127'b0, b16.out_stb}, 128'b0);
        chk("unbal_in_ack2", {125'b0, b16.in_ack}, {125'b0, 3'b111});
        for (int k = 0; k < 15; k++) cyc16(3'b110, rnd96(), 1'b1);
        for (int k = 0; k < 3; k++) cyc16(3'b000, '0, 1'b1);
        chk("unbal_drained", {113'b0, b16.level}, 128'b0);

        // Backpressure: beat 1 held, then five back-to-back beats
        for (int k = 0; k < 5; k++) cyc16(3'b111, rnd96(), 1'b0);
        b1 = {q16[2][0], q16[1][0], q16[0][0]};
        for (int k = 0; k < 10; k++) begin
            cyc16(3'b000, '0, 1'b0);
            chk("bp_hold_stb", {127'b0, b16.out_stb}, {127'b0, 1'b1});
            chk("bp_hold_data", {32'b0, b16.out_data}, {32'b0, b1});
        end
        for (int k = 0; k < 5; k++) begin
            chk("bp_stream_stb", {127'b0, b16.out_stb}, {127'b0, 1'b1});
            cyc16(3'b000, '0, 1'b1);
        end
        chk("bp_done_stb", {127'b0, b16.out_stb}, 128'b0);
        chk("bp_done_level", {113'b0, b16.level}, 128'b0);

        // Randomized traffic, then rebalance channels so everything drains
        for (int k = 0; k < 300; k++) begin
            cyc16(3'($urandom_range(0, 7)), rnd96(), ($urandom_range(0, 3) != 0));
        end
        for (int k = 0; k < 80; k++) begin
            maxsz = 0;
            for (int c = 0; c < 3; c++) if (q16[c].size() > maxsz) maxsz = q16[c].size();
            stb = '0;
            for (int c = 0; c < 3; c++) stb[c] = (q16[c].size() < maxsz);
            cyc16(stb, rnd96(), 1'b1);
        end
        left = q16[0].size() + q16[1].size() + q16[2].size();
        chk("rand_model_empty", 128'(left), 128'b0);
        chk("rand_level", {113'b0, b16.level}, 128'b0);
        chk("rand_stb", {127'b0, b16.out_stb}, 128'b0);

        // Reset pulse between edges with data queued and presented
        for (int k = 0; k < 7; k++) cyc16(3'b111, rnd96(), 1'b0);
        chk("mid_pre_stb", {127'b0, b16.out_stb}, {127'b0, 1'b1});
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_stb", {127'b0, b16.out_stb}, 128'b0);
        chk("mid_rst_level", {113'b0, b16.level}, 128'b0);
        chk("mid_rst_in_ack", {125'b0, b16.in_ack}, {125'b0, 3'b111});
        #2 rstn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            q16[c].delete();
            q5[c].delete();
        end
        d = rnd96();
        cyc16(3'b111, d, 1'b1);
        cyc16(3'b000, '0, 1'b1);
        chk("mid_fresh_data", {32'b0, b16.out_data}, {32'b0, d});
        cyc16(3'b000, '0, 1'b1);
        chk("mid_fresh_done", {127'b0, b16.out_stb}, 128'b0);
        chk("mid_fresh_level", {113'b0, b16.level}, 128'b0);

        // Wrap on DEPTH=5: 23 sequential words per channel
        for (int c = 0; c < 3; c++) next5[c] = 0;
        for (int k = 0; k < 600 && beats5 < 23; k++) begin
            stb = '0;
            d   = '0;
            for (int c = 0; c < 3; c++) begin
                stb[c] = (next5[c] < 23) && ($urandom_range(0, 3) != 0);
                d[c*32 +: 32] = 32'(next5[c]);
            end
            cyc5(stb, d, ($urandom_range(0, 3) != 0), acc);
            for (int c = 0; c < 3; c++) if (acc[c]) next5[c]++;
            over = 1'b0;
            for (int c = 0; c < 3; c++) if (b5.level[c*4 +: 4] > 4'd5) over = 1'b1;
            chk("wrap_level_max", {127'b0, over}, 128'b0);
        end
        chk("wrap_beats", 128'(beats5), 128'd23);
        chk("wrap_level_end", {116'b0, b5.level}, 128'b0);
        chk("wrap_stb_end", {127'b0, b5.out_stb}, 128'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
